counter_trigger_gen: RTL and testbench

- Generates the internal `counter_trigger` level consumed by the reset manager in internal-trigger mode.
- When armed, it counts a selectable reference (clock cycles or rising edges of an external reference pulse) up to a programmable preset.
- On reaching the preset it asserts the trigger high and holds it.
- When disabled, the output is held permanently high, so the downstream AND with the trigger-enable bit passes through unaffected.

---
 rtl/counter_trigger_gen_if.sv | 28 ++
 rtl/counter_trigger_gen.sv | 133 +++++++++++++
 tb/tb_counter_trigger_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_trigger_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | counter_trigger_gen_if : control/status bundle of the counter trigger
// | Rev 1.0
// +----------------------------------------------------------------------------
interface counter_trigger_gen_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     enable;
  logic                     arm;
  logic                     source_sel;
  logic                     ref_pulse;
  logic [COUNTER_WIDTH-1:0] preset;
  logic                     counter_trigger;
  logic [COUNTER_WIDTH-1:0] count;
  logic [31:0]              status;

  modport master (
    output enable, arm, source_sel, ref_pulse, preset,
    input  counter_trigger, count, status
  );

  modport slave (
    input  enable, arm, source_sel, ref_pulse, preset,
    output counter_trigger, count, status
  );
endinterface
`default_nettype wire

// File: rtl/counter_trigger_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | counter_trigger_gen : internal counter_trigger level for the reset manager
// | Optional fire counter: COUNTER_TRIGGER_FIRE_COUNT_EN          Rev 1.0
// +----------------------------------------------------------------------------
module counter_trigger_gen #(
  parameter int COUNTER_WIDTH    = 32,
  parameter int FIRE_COUNT_WIDTH = 16
) (
  input wire                   clk,
  input wire                   areset,
  counter_trigger_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] cnt_nxt;
  logic                     trig;
  logic                     trig_nxt;
  logic                     fire;

  logic                     enable_q;
  logic                     arm_q;
  logic                     arm_d;
  logic                     ref_s1;
  logic                     ref_s2;
  logic                     ref_d;
  logic                     arm_edge;
  logic                     ref_tick;
  logic                     tick;

  logic [FIRE_COUNT_WIDTH-1:0] fire_cnt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      enable_q <= 1'b0;
      arm_q    <= 1'b0;
      arm_d    <= 1'b0;
      ref_s1   <= 1'b0;
      ref_s2   <= 1'b0;
      ref_d    <= 1'b0;
    end else begin
      enable_q <= bus.enable;
      arm_q    <= bus.arm;
      arm_d    <= arm_q;
      ref_s1   <= bus.ref_pulse;
      ref_s2   <= ref_s1;
      ref_d    <= ref_s2;
    end
  end

  assign arm_edge = arm_q & ~arm_d;
  assign ref_tick = ref_s2 & ~ref_d;
  assign tick     = bus.source_sel ? ref_tick : 1'b1;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      cnt   <= '0;
      trig  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      trig  <= trig_nxt;
    end
  end

  // Trigger follows the registered state, so it rises one edge after FIRED is entered.
  assign trig_nxt = ~enable_q | (state == FIRED);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    if (!enable_q) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm_edge) begin
            state_nxt = ARMED;
            cnt_nxt   = '0;
          end
        end
        ARMED: begin
          if (cnt >= bus.preset) begin
            state_nxt = FIRED;
            fire      = 1'b1;
          end else if (tick && (cnt != '1)) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        FIRED: begin
          if (arm_edge) begin
            state_nxt = ARMED;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef COUNTER_TRIGGER_FIRE_COUNT_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fire_cnt <= '0;
    end else if (fire && (fire_cnt != '1)) begin
      fire_cnt <= fire_cnt + 1'b1;
    end
  end
`else
  assign fire_cnt = '0;
`endif

  assign bus.counter_trigger = trig;
  assign bus.count           = cnt;
  assign bus.status          = {16'(fire_cnt), 13'd0, enable_q,
                                (state == FIRED), (state == ARMED)};

endmodule
`default_nettype wire

// File: tb/tb_counter_trigger_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_counter_trigger_gen : directed self-checking bench for counter_trigger_gen
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_counter_trigger_gen;

  logic clk;
  logic areset;
  int   tests;
  int   fails;

  counter_trigger_gen_if #(.COUNTER_WIDTH(32)) bus ();

  counter_trigger_gen #(
    .COUNTER_WIDTH    (32),
    .FIRE_COUNT_WIDTH (16)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

`ifdef COUNTER_TRIGGER_FIRE_COUNT_EN
  localparam logic [31:0] FC_EXP = 32'd4;
`else
  localparam logic [31:0] FC_EXP = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    areset         = 1'b1;
    bus.enable     = 1'b0;
    bus.arm        = 1'b0;
    bus.source_sel = 1'b0;
    bus.ref_pulse  = 1'b0;
    bus.preset     = 32'd0;

    // Reset and disabled
    tick(3);
    check("rst_trig", {31'd0, bus.counter_trigger}, 32'd1);
    areset = 1'b0;
    tick(3);
    check("dis_trig", {31'd0, bus.counter_trigger}, 32'd1);
    check("dis_count", bus.count, 32'd0);
    check("dis_status", bus.status, 32'd0);

    // Clock-cycle count, preset 10
    bus.enable = 1'b1;
    bus.preset = 32'd10;
    tick(3);
    check("en_trig", {31'd0, bus.counter_trigger}, 32'd0);
    check("en_status", bus.status, 32'h4);
    bus.arm = 1'b1;
    tick(7);
    check("cyc_count_mid", bus.count, 32'd5);
    tick(5);
    check("cyc_count_e12", bus.count, 32'd10);
    check("cyc_trig_e12", {31'd0, bus.counter_trigger}, 32'd0);
    check("cyc_status_e12", bus.status, 32'h5);
    tick(1);
    check("cyc_trig_e13", {31'd0, bus.counter_trigger}, 32'd0);
    check("cyc_status_e13", bus.status, 32'h6);
    tick(1);
    check("cyc_trig_e14", {31'd0, bus.counter_trigger}, 32'd1);
    tick(5);
    check("cyc_count_frozen", bus.count, 32'd10);
    check("cyc_trig_hold", {31'd0, bus.counter_trigger}, 32'd1);

    // Reference-pulse count, preset 3, re-armed from FIRED
    bus.arm        = 1'b0;
    bus.source_sel = 1'b1;
    bus.preset     = 32'd3;
    tick(3);
    bus.arm = 1'b1;
    tick(5);
    check("ref_idle_count", bus.count, 32'd0);
    check("ref_idle_trig", {31'd0, bus.counter_trigger}, 32'd0);
    for (int p = 0; p < 5; p++) begin
      bus.ref_pulse = 1'b1;
      tick(2);
      bus.ref_pulse = 1'b0;
      check($sformatf("ref_cnt_e2_p%0d", p), bus.count, (p < 3) ? 32'(p) : 32'd3);
      tick(1);
      check($sformatf("ref_cnt_e3_p%0d", p), bus.count, (p < 2) ? 32'(p + 1) : 32'd3);
      if (p == 2) begin
        tick(1);
        check("ref_trig_e4", {31'd0, bus.counter_trigger}, 32'd0);
        tick(1);
        check("ref_trig_e5", {31'd0, bus.counter_trigger}, 32'd1);
        tick(15);
      end else begin
        tick(17);
      end
    end
    check("ref_trig_end", {31'd0, bus.counter_trigger}, 32'd1);

    // Preset zero from IDLE, arm held, re-arm in FIRED
    bus.arm        = 1'b0;
    bus.source_sel = 1'b0;
    bus.preset     = 32'd0;
    bus.enable     = 1'b0;
    tick(3);
    check("p0_dis_trig", {31'd0, bus.counter_trigger}, 32'd1);
    check("p0_dis_count", bus.count, 32'd0);
    check("p0_dis_status", bus.status, 32'd0);
    bus.enable = 1'b1;
    tick(3);
    bus.arm = 1'b1;
    tick(2);
    check("p0_status_e2", bus.status, 32'h5);
    tick(1);
    check("p0_trig_e3", {31'd0, bus.counter_trigger}, 32'd0);
    tick(1);
    check("p0_trig_e4", {31'd0, bus.counter_trigger}, 32'd1);
    tick(10);
    check("hold_trig", {31'd0, bus.counter_trigger}, 32'd1);
    check("hold_status", bus.status, 32'h6);
    bus.arm = 1'b0;
    tick(3);
    bus.arm = 1'b1;
    tick(2);
    check("rearm_trig_e2", {31'd0, bus.counter_trigger}, 32'd1);
    check("rearm_status_e2", bus.status, 32'h5);
    tick(1);
    check("rearm_trig_e3", {31'd0, bus.counter_trigger}, 32'd0);
    tick(1);
    check("rearm_trig_e4", {31'd0, bus.counter_trigger}, 32'd1);

    // Mid-operation disable with a simultaneous arm edge
    bus.arm    = 1'b0;
    bus.preset = 32'd1000;
    bus.enable = 1'b0;
    tick(3);
    bus.enable = 1'b1;
    tick(3);
    bus.arm = 1'b1;
    tick(10);
    bus.arm = 1'b0;
    tick(492);
    check("mid_count_500", bus.count, 32'd500);
    bus.enable = 1'b0;
    bus.arm    = 1'b1;
    tick(1);
    check("mid_count_e1", bus.count, 32'd501);
    tick(1);
    check("mid_count_e2", bus.count, 32'd0);
    check("mid_trig_e2", {31'd0, bus.counter_trigger}, 32'd1);
    check("mid_status_e2", bus.status, 32'd0);
    bus.enable = 1'b1;
    tick(10);
    check("mid_no_rearm", bus.status, 32'h4);
    check("mid_trig_idle", {31'd0, bus.counter_trigger}, 32'd0);

    // Lowering preset below the live count fires on the next edge
    bus.arm = 1'b0;
    tick(2);
    bus.arm = 1'b1;
    tick(22);
    check("live_count", bus.count, 32'd20);
    bus.preset = 32'd5;
    tick(1);
    check("live_status", bus.status, 32'h6);
    check("live_count_frz", bus.count, 32'd20);
    tick(1);
    check("live_trig", {31'd0, bus.counter_trigger}, 32'd1);

    // Fire counter: four arm/fire cycles after a fresh reset
    areset = 1'b1;
    bus.arm = 1'b0;
    tick(1);
    areset = 1'b0;
    bus.preset = 32'd0;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      bus.arm = 1'b1;
      tick(6);
      bus.arm = 1'b0;
      tick(3);
    end
    check("fc_value", {16'd0, bus.status[31:16]}, FC_EXP);
    check("fc_low", {16'd0, bus.status[15:0]}, 32'h6);
    bus.preset = 32'd1000;
    bus.arm    = 1'b1;
    tick(4);
    check("fc_armed", {16'd0, bus.status[15:0]}, 32'h5);
    areset = 1'b1;
    #2;
    check("async_trig", {31'd0, bus.counter_trigger}, 32'd1);
    check("async_count", bus.count, 32'd0);
    check("async_status", bus.status, 32'd0);
    tick(1);
    areset = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
